// File: rtl/bp_pkg.sv
// Shared branch-predictor package: default widths, the chooser init value
// and the sweep FSM state type.
package bp_pkg;

    localparam int unsigned IDX_W_DEF = 10;
    localparam int unsigned CTR_W_DEF = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } chooser_state_t;

    // Weakly-Local start point: the largest value whose MSB is still 0.
    function automatic int unsigned init_ctr(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// Next-state logic for a saturating counter trained by two component
// predictors; write-enable is asserted only when the value actually changes.
module sat_ctr_next #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_g_ok,
    input  logic             i_l_ok,
    output logic [CTR_W-1:0] o_ctr_next,
    output logic             o_we
);

    always_comb begin
        o_ctr_next = i_ctr;
        o_we       = 1'b0;
        if (i_g_ok && !i_l_ok) begin
            if (i_ctr != '1) begin
                o_ctr_next = i_ctr + 1'b1;
                o_we       = 1'b1;
            end
        end else if (!i_g_ok && i_l_ok) begin
            if (i_ctr != '0) begin
                o_ctr_next = i_ctr - 1'b1;
                o_we       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tournament_chooser.sv
// Tournament chooser table: selects Gshare vs Local per GPT index, trains
// itself on resolved branches and clears its own table after reset.
module tournament_chooser
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned CTR_W    = CTR_W_DEF,
    parameter int unsigned INIT_CTR = init_ctr(CTR_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lk_idx,
    input  logic             lk_gshare_pred,
    input  logic             lk_local_pred,
    output logic             lk_use_gshare,
    output logic             lk_pred,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_idx,
    input  logic [1:0]       up_pc_lo,
    input  logic             up_gshare_pred,
    input  logic             up_local_pred,
    input  logic             up_taken,
    output logic             init_busy,
    output logic [15:0]      wrong_choice_cnt
);

    localparam int unsigned      DEPTH  = 1 << IDX_W;
    localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT_CTR);

    chooser_state_t   r_state;
    chooser_state_t   w_state_next;
    logic [IDX_W-1:0] r_ptr;
    logic [15:0]      r_wrong_cnt;
    logic [CTR_W-1:0] r_table [DEPTH];

    logic             w_lk_msb;
    logic             w_up_fire;
    logic [CTR_W-1:0] w_up_old;
    logic             w_g_ok;
    logic             w_l_ok;
    logic [CTR_W-1:0] w_ctr_next;
    logic             w_ctr_we;
    logic             w_wrong;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_addr;
    logic [CTR_W-1:0] w_wr_data;

    // Lookup is suppressed while the table still holds garbage.
    assign w_lk_msb      = r_table[lk_idx][CTR_W-1];
    assign lk_use_gshare = (r_state == ST_RUN) && w_lk_msb;
    assign lk_pred       = lk_use_gshare ? lk_gshare_pred : lk_local_pred;
    assign init_busy     = (r_state == ST_INIT);
    assign wrong_choice_cnt = r_wrong_cnt;

    assign w_up_fire = up_valid && (up_pc_lo == 2'b00) && (r_state == ST_RUN);
    assign w_up_old  = r_table[up_idx];
    assign w_g_ok    = (up_gshare_pred == up_taken);
    assign w_l_ok    = (up_local_pred == up_taken);

    sat_ctr_next #(
        .CTR_W (CTR_W)
    ) u_sat_ctr_next (
        .i_ctr      (w_up_old),
        .i_g_ok     (w_g_ok),
        .i_l_ok     (w_l_ok),
        .o_ctr_next (w_ctr_next),
        .o_we       (w_ctr_we)
    );

    assign w_wrong = w_up_fire &&
                     (w_up_old[CTR_W-1] ? (!w_g_ok && w_l_ok) : (w_g_ok && !w_l_ok));

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = up_idx;
        w_wr_data = w_ctr_next;
        if (r_state == ST_INIT) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_ptr;
            w_wr_data = INIT_V;
        end else begin
            w_wr_en   = w_up_fire && w_ctr_we;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_INIT) && (r_ptr == '1)) begin
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_ptr       <= '0;
            r_wrong_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_wrong && (r_wrong_cnt != '1)) begin
                r_wrong_cnt <= r_wrong_cnt + 16'd1;
            end
        end
    end

    // The table has no reset; the sweep is what makes its contents valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_table[w_wr_addr] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_tournament_chooser.sv
// Self-checking bench for tournament_chooser with a counter-array reference model.
module tb_tournament_chooser;

    localparam int IDX_W = 10;
    localparam int CTR_W = 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CMAX  = (1 << CTR_W) - 1;
    localparam int CHALF = 1 << (CTR_W - 1);

    logic             clk;
    logic             rst;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_gshare_pred;
    logic             lk_local_pred;
    logic             lk_use_gshare;
    logic             lk_pred;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic [1:0]       up_pc_lo;
    logic             up_gshare_pred;
    logic             up_local_pred;
    logic             up_taken;
    logic             init_busy;
    logic [15:0]      wrong_choice_cnt;

    int errors = 0;
    int checks = 0;

    int m_ctr [DEPTH];
    int m_wcc;
    bit m_busy;

    tournament_chooser #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lk_idx           (lk_idx),
        .lk_gshare_pred   (lk_gshare_pred),
        .lk_local_pred    (lk_local_pred),
        .lk_use_gshare    (lk_use_gshare),
        .lk_pred          (lk_pred),
        .up_valid         (up_valid),
        .up_idx           (up_idx),
        .up_pc_lo         (up_pc_lo),
        .up_gshare_pred   (up_gshare_pred),
        .up_local_pred    (up_local_pred),
        .up_taken         (up_taken),
        .init_busy        (init_busy),
        .wrong_choice_cnt (wrong_choice_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_use_g(input int idx);
        return !m_busy && (m_ctr[idx] >= CHALF);
    endfunction

    // One clock: model applies the update visible at the edge, returns at the negedge.
    task automatic tick();
        bit g_ok, l_ok, chose_g;
        int c;
        @(posedge clk);
        if (!rst) begin
            m_busy = 1'b1;
            m_wcc  = 0;
        end else if (!m_busy && up_valid && up_pc_lo == 2'b00) begin
            g_ok    = (up_gshare_pred == up_taken);
            l_ok    = (up_local_pred == up_taken);
            c       = m_ctr[up_idx];
            chose_g = (c >= CHALF);
            if (chose_g ? (!g_ok && l_ok) : (g_ok && !l_ok))
                if (m_wcc < 65535) m_wcc++;
            if (g_ok && !l_ok && c < CMAX) c++;
            else if (!g_ok && l_ok && c > 0) c--;
            m_ctr[up_idx] = c;
        end
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic set_up(input int idx, input bit g, input bit l, input bit t, input logic [1:0] lo);
        up_valid       = 1'b1;
        up_idx         = IDX_W'(idx);
        up_gshare_pred = g;
        up_local_pred  = l;
        up_taken       = t;
        up_pc_lo       = lo;
    endtask

    task automatic set_lk(input int idx);
        lk_idx         = IDX_W'(idx);
        lk_gshare_pred = 1'($urandom);
        lk_local_pred  = 1'($urandom);
        #1;
    endtask

    task automatic sweep_done();
        m_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = CHALF - 1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        m_busy = 1'b1;
        m_wcc = 0;
        repeat (3) tick();
        set_lk(0);
        checks++;
        if (init_busy !== 1'b1 || wrong_choice_cnt !== 16'd0 || lk_use_gshare !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b wcc=%0d use_g=%b, want 1 0 0",
                     init_busy, wrong_choice_cnt, lk_use_gshare);
        end
        rst = 1'b1;
        n = 0;
        while (init_busy === 1'b1 && n < 3000) begin
            set_lk(int'($urandom_range(DEPTH - 1)));
            if (n % 97 == 0) begin
                checks++;
                if (lk_use_gshare !== 1'b0 || lk_pred !== lk_local_pred) begin
                    errors++;
                    $display("FAIL sweep_lookup: use_g=%b pred=%b, want 0 %b",
                             lk_use_gshare, lk_pred, lk_local_pred);
                end
            end
            tick();
            n++;
        end
        sweep_done();
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL sweep_len: got %0d cycles, want %0d", n, DEPTH);
        end
    endtask

    task automatic test_init_values();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_lk(i);
            if (lk_use_gshare !== 1'b0 || lk_pred !== lk_local_pred) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_values: %0d indices not weakly Local, want 0", bad);
        end
    endtask

    task automatic test_train_gshare();
        bit exp_ug [3] = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            set_up(5, 1, 0, 1, 2'b00);
            set_lk(5);
            checks++;
            if (lk_use_gshare !== exp_ug[k] ||
                lk_pred !== (exp_ug[k] ? lk_gshare_pred : lk_local_pred)) begin
                errors++;
                $display("FAIL train_g step%0d: use_g=%b pred=%b, want %b", k,
                         lk_use_gshare, lk_pred, exp_ug[k]);
            end
            tick();
        end
        checks++;
        if (m_ctr[5] != 3 || wrong_choice_cnt !== 16'd1 || m_wcc != 1) begin
            errors++;
            $display("FAIL train_g end: wcc=%0d model_ctr=%0d, want wcc=1 ctr=3",
                     wrong_choice_cnt, m_ctr[5]);
        end
    endtask

    task automatic test_train_local();
        int base;
        int exp_wcc [4];
        bit exp_ug [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        base = int'(wrong_choice_cnt);
        exp_wcc = '{base + 1, base + 2, base + 2, base + 2};
        for (int k = 0; k < 4; k++) begin
            set_up(5, 0, 1, 1, 2'b00);
            set_lk(5);
            checks++;
            if (lk_use_gshare !== exp_ug[k]) begin
                errors++;
                $display("FAIL train_l use_g step%0d: got %b want %b", k, lk_use_gshare, exp_ug[k]);
            end
            tick();
            checks++;
            if (int'(wrong_choice_cnt) != exp_wcc[k] || int'(wrong_choice_cnt) != m_wcc) begin
                errors++;
                $display("FAIL train_l wcc step%0d: got %0d want %0d", k, wrong_choice_cnt, exp_wcc[k]);
            end
        end
    endtask

    task automatic test_dropped();
        logic [15:0] w0;
        logic [1:0] los [3] = '{2'b10, 2'b01, 2'b11};
        w0 = wrong_choice_cnt;
        for (int k = 0; k < 3; k++) begin
            set_up(9, 1, 0, 1, los[k]);
            tick();
        end
        set_up(9, 1, 1, 1, 2'b00); tick();
        set_up(9, 0, 0, 1, 2'b00); tick();
        set_up(9, 1, 1, 0, 2'b00); tick();
        set_lk(9);
        checks++;
        if (lk_use_gshare !== 1'b0 || wrong_choice_cnt !== w0) begin
            errors++;
            $display("FAIL dropped: use_g=%b wcc=%0d, want 0 %0d", lk_use_gshare, wrong_choice_cnt, w0);
        end
        // A single real +1 must only reach the MSB boundary, proving idx 9 stayed at init.
        set_up(9, 1, 0, 1, 2'b00); tick();
        set_up(9, 0, 1, 1, 2'b00); tick();
        set_lk(9);
        checks++;
        if (lk_use_gshare !== 1'b0 || m_ctr[9] != CHALF - 1) begin
            errors++;
            $display("FAIL dropped_probe: use_g=%b, want 0", lk_use_gshare);
        end
    endtask

    task automatic test_same_cycle();
        set_up(7, 1, 0, 1, 2'b00);
        set_lk(7);
        checks++;
        if (lk_use_gshare !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_old: use_g=%b want 0", lk_use_gshare);
        end
        tick();
        set_lk(7);
        checks++;
        if (lk_use_gshare !== 1'b1 || lk_pred !== lk_gshare_pred) begin
            errors++;
            $display("FAIL same_cycle_new: use_g=%b want 1", lk_use_gshare);
        end
    endtask

    task automatic test_random();
        int bad_lk = 0, bad_wcc = 0;
        bit eu;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(9) < 8)
                set_up(int'($urandom_range(7)), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(9) < 7) ? 2'b00 : 2'($urandom));
            set_lk(int'($urandom_range(7)));
            eu = m_use_g(int'(lk_idx));
            if (lk_use_gshare !== eu || lk_pred !== (eu ? lk_gshare_pred : lk_local_pred)) begin
                bad_lk++;
                if (bad_lk < 5)
                    $display("FAIL rand_lookup k=%0d idx=%0d: use_g=%b want %b", k, lk_idx, lk_use_gshare, eu);
            end
            tick();
            if (int'(wrong_choice_cnt) != m_wcc) begin
                bad_wcc++;
                if (bad_wcc < 5)
                    $display("FAIL rand_wcc k=%0d: got %0d want %0d", k, wrong_choice_cnt, m_wcc);
            end
        end
        checks++;
        if (bad_lk != 0) errors++;
        checks++;
        if (bad_wcc != 0) errors++;
    endtask

    task automatic test_reset_mid_sweep();
        int n, bad;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 500; k++) begin
            set_up(int'($urandom_range(3)), 1, 0, 1, 2'b00);
            tick();
        end
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy: got %b want 1", init_busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (init_busy !== 1'b1 || wrong_choice_cnt !== 16'd0 || lk_use_gshare !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_reset: busy=%b wcc=%0d use_g=%b, want 1 0 0",
                     init_busy, wrong_choice_cnt, lk_use_gshare);
        end
        repeat (2) tick();
        rst = 1'b1;
        n = 0;
        while (init_busy === 1'b1 && n < 3000) begin
            set_up(int'($urandom_range(3)), 1, 0, 1, 2'b00);
            tick();
            n++;
        end
        sweep_done();
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL resweep_len: got %0d cycles want %0d", n, DEPTH);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            set_lk(i);
            if (lk_use_gshare !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || wrong_choice_cnt !== 16'd0) begin
            errors++;
            $display("FAIL resweep_drop: %0d trained indices, wcc=%0d, want 0 0", bad, wrong_choice_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        lk_idx = '0; lk_gshare_pred = 1'b0; lk_local_pred = 1'b0;
        up_valid = 1'b0; up_idx = '0; up_pc_lo = 2'b00;
        up_gshare_pred = 1'b0; up_local_pred = 1'b0; up_taken = 1'b0;
        @(negedge clk);
        test_reset();
        test_init_values();
        test_train_gshare();
        test_train_local();
        test_dropped();
        test_same_cycle();
        test_random();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tournament_chooser.md
# tournament_chooser

Parametrised chooser (meta-predictor) table for the tournament branch predictor. It indexes a table of `CTR_W`-bit saturating counters with the Gshare GPT index and selects between the Gshare and Local predictions at fetch. It trains itself on resolved branches with an internal read-modify-write, so the external chooser FSM is no longer needed. After reset it clears its own table with a sweep, because the table has no per-entry reset.

## Interface
- `IDX_W`, default 10: table index width; the table depth is 2^`IDX_W`.
- `CTR_W`, default 2: chooser counter width, minimum 2. MSB=1 selects Gshare.
- `INIT_CTR`, default 2^(`CTR_W`-1)-1: value written by the init sweep (weakly Local).
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `lk_idx` input, `IDX_W`: lookup index (same value as the Gshare GPT index).
- `lk_gshare_pred` input, 1: Gshare prediction for the lookup.
- `lk_local_pred` input, 1: Local prediction for the lookup.
- `lk_use_gshare` output, 1: selected component (1 = Gshare).
- `lk_pred` output, 1: final taken prediction.
- `up_valid` input, 1: resolved-branch update strobe (EX stage).
- `up_idx` input, `IDX_W`: index used when this branch was predicted.
- `up_pc_lo` input, 2: `pc_ex[1:0]`.
- `up_gshare_pred` input, 1: the Gshare prediction that was made for this branch.
- `up_local_pred` input, 1: the Local prediction that was made for this branch.
- `up_taken` input, 1: actual outcome.
- `init_busy` output, 1: table sweep in progress.
- `wrong_choice_cnt` output, 16: saturating count of updates where the chosen component was wrong and the other was right.

## Operation
- **Lookup (combinational):**
  - `lk_use_gshare` = MSB of `table[lk_idx]`.
  - `lk_pred` = `lk_gshare_pred` when `lk_use_gshare`=1, else `lk_local_pred`.
- **Update** fires when `up_valid`=1, `up_pc_lo`=2'b00 and `init_busy`=0. Otherwise the update is dropped with no state change.
- Define g_ok = (`up_gshare_pred`==`up_taken`) and l_ok = (`up_local_pred`==`up_taken`).
  - g_ok & !l_ok: counter +1, saturating at 2^`CTR_W`-1.
  - !g_ok & l_ok: counter −1, saturating at 0.
  - Both right or both wrong: counter unchanged, no write.
- **wrong_choice_cnt:** increments by 1 on a valid update when the old counter MSB selected the component that was wrong and the other component was right. Saturates at 16'hFFFF.
- **Init FSM:**
  - States: INIT, RUN.
  - Reset enters INIT with the sweep pointer at 0.
  - In INIT, each cycle writes `INIT_CTR` to `table[ptr]` and increments ptr.
  - When ptr = 2^`IDX_W`-1 is written, the FSM moves to RUN on that edge.
  - RUN is terminal until the next reset.
- **During INIT:**
  - `lk_use_gshare` = 0 and `lk_pred` = `lk_local_pred`, independent of table contents.
  - Updates are ignored.

## Timing
- **Reset values:** `init_busy`=1, `wrong_choice_cnt`=0, FSM=INIT, ptr=0. `lk_use_gshare`=0 while in reset.
- **Reset mid-sweep or mid-run:** aborts immediately and restarts the sweep from 0 after `rst` deasserts.
- **Sweep length:** exactly 2^`IDX_W` cycles after deassertion. `init_busy` falls after the edge that writes the last entry, i.e. 1024 cycles for `IDX_W`=10.
- **Lookup latency:** 0 cycles; read is asynchronous.
- **Update latency:** the write lands on the rising edge of the update cycle.
  - A lookup to the same index in the same cycle sees the old value.
  - A lookup to that index in the next cycle sees the new value. No forwarding.
- **Back-to-back updates to one index on consecutive cycles:** the second update reads the first's result, because the write completes before the next read. Two +1 steps must give +2.
- **Simultaneous lookup and update, different indices:** independent; no stall.
- **wrong_choice_cnt:** updates on the same edge as the table write.

## Structure
- **Shared package `bp_pkg`:**
  - `IDX_W` and `CTR_W` defaults.
  - `INIT_CTR` function.
  - Localparams for FSM state encodings `ST_INIT` and `ST_RUN`.
- **Sub-module `sat_ctr_next`:** combinational.
  - Inputs: old counter, g_ok, l_ok.
  - Outputs: next counter, write-enable.
  - Parametrised by `CTR_W`; reused by the Local and Gshare PHTs.
- **Table:** plain register array with one write port shared by the sweep and the update. A 2:1 mux on address/data is selected by FSM state.

## Test plan
- Reset, then count cycles → `init_busy` stays 1 for exactly 1024 cycles. Every index then reads `lk_use_gshare`=0 with `INIT_CTR`=1.
- After init, idx 5 gets 3 updates (gshare=1, local=0, taken=1) on consecutive cycles → counter 1→2→3→3. `lk_use_gshare`=1 from the cycle after the first update. `lk_pred` follows `lk_gshare_pred`.
- Idx 5 at 3 gets 4 updates (gshare=0, local=1, taken=1) → 2,1,0,0. `wrong_choice_cnt` increments on the first two only (MSB=1 chose the wrong component).
- Update idx 9 with `up_pc_lo`=2'b10, or both predictors agreeing → no change at idx 9 and `wrong_choice_cnt` unchanged.
- Lookup idx 7 in the same cycle as an update to idx 7 → old MSB seen that cycle, new MSB seen the next cycle.
- Assert `rst`=0 at sweep cycle 500 and release → `init_busy` is 1 for a fresh 1024 cycles. Updates issued during the sweep are dropped.
